// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the RAM port of the memory arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface mem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port read-first RAM: round-robin or fixed
// priority, m1 burst lock with a starvation breaker, read response routing.
module mem_arbiter #(
    parameter int RR_ENABLE = 1,
    parameter int LOCK_MAX  = 16
) (
    input  logic         clk,
    input  logic         rstn,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {RS_NONE = 2'd0, RS_M0 = 2'd1, RS_M1 = 2'd2} rsel_t;

    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    logic       r_prio;   // 0: m0 wins a tie, 1: m1 wins a tie
    logic       r_locked;
    logic [7:0] r_starve;
    rsel_t      r_rsel;

    logic       w_brk;
    logic       w_lock_win;
    logic       w_g0;
    logic       w_g1;
    logic       w_prio_n;
    logic       w_locked_n;
    logic [7:0] w_starve_n;
    rsel_t      w_rsel_n;

    always_comb begin
        w_brk      = bus.m0_req && (r_starve >= LMAX);
        w_lock_win = r_locked && bus.m1_req && (r_starve < LMAX);
        w_g0       = 1'b0;
        w_g1       = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            if (w_brk)                            w_g0 = 1'b1;
            else if (w_lock_win)                  w_g1 = 1'b1;
            else if ((RR_ENABLE != 0) && r_prio)  w_g1 = 1'b1;
            else                                  w_g0 = 1'b1;
        end else begin
            w_g0 = bus.m0_req;
            w_g1 = bus.m1_req;
        end
    end

    always_comb begin
        bus.ram_en   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_di   = '0;
        if (w_g0) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = bus.m0_we;
            bus.ram_addr = bus.m0_addr;
            bus.ram_di   = bus.m0_wdata;
        end else if (w_g1) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = bus.m1_we;
            bus.ram_addr = bus.m1_addr;
            bus.ram_di   = bus.m1_wdata;
        end
    end

    always_comb begin
        w_prio_n = r_prio;
        if (w_g0)      w_prio_n = 1'b1;
        else if (w_g1) w_prio_n = 1'b0;

        // a lock only survives a cycle in which m1 actually owned the RAM
        w_locked_n = w_g1 && bus.m1_lock;

        if (!bus.m0_req || w_g0)  w_starve_n = 8'd0;
        else if (r_starve < LMAX) w_starve_n = r_starve + 8'd1;
        else                      w_starve_n = r_starve;

        if (w_g0 && !bus.m0_we)      w_rsel_n = RS_M0;
        else if (w_g1 && !bus.m1_we) w_rsel_n = RS_M1;
        else                         w_rsel_n = RS_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_prio   <= 1'b0;
            r_locked <= 1'b0;
            r_starve <= 8'd0;
            r_rsel   <= RS_NONE;
        end else begin
            r_prio   <= w_prio_n;
            r_locked <= w_locked_n;
            r_starve <= w_starve_n;
            r_rsel   <= w_rsel_n;
        end
    end

    assign bus.m0_gnt    = w_g0;
    assign bus.m1_gnt    = w_g1;
    assign bus.m0_rvalid = (r_rsel == RS_M0);
    assign bus.m1_rvalid = (r_rsel == RS_M1);
    assign bus.m0_rdata  = bus.ram_dout;
    assign bus.m1_rdata  = bus.ram_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations (RR, fixed priority, LOCK_MAX=4)
// run side by side against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;
    localparam int N = 3;

    function automatic int rr_of(int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int lm_of(int k);
        return (k == 2) ? 4 : 16;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic mem_clr;
    logic        m0_req[N], m0_we[N], m1_req[N], m1_we[N], m1_lock[N];
    logic [31:0] m0_addr[N], m0_wdata[N], m1_addr[N], m1_wdata[N];
    logic        g0[N], g1[N], rv0[N], rv1[N], ren[N], rwe[N];
    logic [31:0] rd0[N], rd1[N], raddr[N], rdi[N];

    mem_arbiter_if bus[N] ();

    for (genvar g = 0; g < N; g++) begin : g_conn
        logic [31:0] mem [64];
        logic [31:0] dout;
        assign bus[g].m0_req   = m0_req[g];
        assign bus[g].m0_we    = m0_we[g];
        assign bus[g].m0_addr  = m0_addr[g];
        assign bus[g].m0_wdata = m0_wdata[g];
        assign bus[g].m1_req   = m1_req[g];
        assign bus[g].m1_we    = m1_we[g];
        assign bus[g].m1_lock  = m1_lock[g];
        assign bus[g].m1_addr  = m1_addr[g];
        assign bus[g].m1_wdata = m1_wdata[g];
        assign bus[g].ram_dout = dout;
        assign g0[g]    = bus[g].m0_gnt;
        assign g1[g]    = bus[g].m1_gnt;
        assign rv0[g]   = bus[g].m0_rvalid;
        assign rv1[g]   = bus[g].m1_rvalid;
        assign rd0[g]   = bus[g].m0_rdata;
        assign rd1[g]   = bus[g].m1_rdata;
        assign ren[g]   = bus[g].ram_en;
        assign rwe[g]   = bus[g].ram_we;
        assign raddr[g] = bus[g].ram_addr;
        assign rdi[g]   = bus[g].ram_di;
        // read-first single-port RAM, 1-cycle latency
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
                dout <= 32'd0;
            end else if (bus[g].ram_en) begin
                dout <= mem[bus[g].ram_addr[5:0]];
                if (bus[g].ram_we) mem[bus[g].ram_addr[5:0]] <= bus[g].ram_di;
            end
        end
    end

    mem_arbiter #(.RR_ENABLE(1), .LOCK_MAX(16)) dut_rr  (.clk(clk), .rstn(rstn), .bus(bus[0]));
    mem_arbiter #(.RR_ENABLE(0), .LOCK_MAX(16)) dut_fix (.clk(clk), .rstn(rstn), .bus(bus[1]));
    mem_arbiter #(.RR_ENABLE(1), .LOCK_MAX(4))  dut_lm4 (.clk(clk), .rstn(rstn), .bus(bus[2]));

    // reference model state
    int          m_prio[N];    // requester that wins the next tie
    int          m_starve[N];
    bit          m_locked[N];
    int          m_pend[N];    // requester owed read data this cycle, -1 none
    logic [31:0] m_pdata[N];
    logic [31:0] ref_mem[N][64];
    bit          gl0[N], gl1[N];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Check one cycle (called just after negedge), advance through the
    // rising edge, update the model and return at the next negedge.
    task automatic step();
        int eg[N];
        logic [31:0] ea, ed;
        logic ew;
        #1;
        for (int k = 0; k < N; k++) begin
            eg[k] = -1;
            if (m0_req[k] && m1_req[k]) begin
                if (m_starve[k] == lm_of(k))                      eg[k] = 0;
                else if (m_locked[k] && m_starve[k] < lm_of(k))   eg[k] = 1;
                else if (rr_of(k) != 0)                           eg[k] = m_prio[k];
                else                                              eg[k] = 0;
            end else if (m0_req[k]) eg[k] = 0;
            else if (m1_req[k])     eg[k] = 1;
            ew = 1'b0; ea = 32'd0; ed = 32'd0;
            if (eg[k] == 0) begin ew = m0_we[k]; ea = m0_addr[k]; ed = m0_wdata[k]; end
            if (eg[k] == 1) begin ew = m1_we[k]; ea = m1_addr[k]; ed = m1_wdata[k]; end
            chk("m0_gnt",    k, 32'(g0[k]),  32'(eg[k] == 0));
            chk("m1_gnt",    k, 32'(g1[k]),  32'(eg[k] == 1));
            chk("ram_en",    k, 32'(ren[k]), 32'(eg[k] >= 0));
            chk("ram_we",    k, 32'(rwe[k]), 32'(ew));
            chk("ram_addr",  k, raddr[k],    ea);
            chk("ram_di",    k, rdi[k],      ed);
            chk("m0_rvalid", k, 32'(rv0[k]), 32'(m_pend[k] == 0));
            chk("m1_rvalid", k, 32'(rv1[k]), 32'(m_pend[k] == 1));
            if (m_pend[k] == 0) chk("m0_rdata", k, rd0[k], m_pdata[k]);
            if (m_pend[k] == 1) chk("m1_rdata", k, rd1[k], m_pdata[k]);
            gl0[k] = g0[k];
            gl1[k] = g1[k];
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            int nxt;
            m_pend[k] = -1;
            if (eg[k] == 0) begin
                if (m0_we[k]) ref_mem[k][m0_addr[k][5:0]] = m0_wdata[k];
                else begin m_pend[k] = 0; m_pdata[k] = ref_mem[k][m0_addr[k][5:0]]; end
            end else if (eg[k] == 1) begin
                if (m1_we[k]) ref_mem[k][m1_addr[k][5:0]] = m1_wdata[k];
                else begin m_pend[k] = 1; m_pdata[k] = ref_mem[k][m1_addr[k][5:0]]; end
            end
            if (!rstn) begin
                m_prio[k] = 0; m_locked[k] = 0; m_starve[k] = 0; m_pend[k] = -1;
            end else begin
                if (eg[k] >= 0) m_prio[k] = 1 - eg[k];
                m_locked[k] = (eg[k] == 1) && m1_lock[k];
                nxt = m_starve[k] + 1;
                if (nxt > lm_of(k)) nxt = lm_of(k);
                m_starve[k] = (!m0_req[k] || eg[k] == 0) ? 0 : nxt;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < N; k++) begin
            m0_req[k] = req; m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = d;
        end
    endtask

    task automatic set_m1(input logic req, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < N; k++) begin
            m1_req[k] = req; m1_we[k] = we; m1_lock[k] = lk; m1_addr[k] = a; m1_wdata[k] = d;
        end
    endtask

    // Random requesters that hold their request until they see a grant.
    task automatic rnd_drive();
        for (int k = 0; k < N; k++) begin
            if (!m0_req[k] || gl0[k]) begin
                m0_req[k]   = ($urandom_range(0, 99) < 60);
                m0_we[k]    = $urandom_range(0, 2) == 0;
                m0_addr[k]  = 32'($urandom_range(0, 63));
                m0_wdata[k] = $urandom;
            end
            if (!m1_req[k] || gl1[k]) begin
                m1_req[k]   = ($urandom_range(0, 99) < 70);
                m1_we[k]    = $urandom_range(0, 2) == 0;
                m1_addr[k]  = 32'($urandom_range(0, 63));
                m1_wdata[k] = $urandom;
            end
            m1_lock[k] = ($urandom_range(0, 99) < 75);
        end
        rstn = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        int first_m0;
        int cnt;
        rstn = 1'b0;
        mem_clr = 1'b1;
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < N; k++) begin
            m_prio[k] = 0; m_starve[k] = 0; m_locked[k] = 0; m_pend[k] = -1;
            m_pdata[k] = 32'd0; gl0[k] = 0; gl1[k] = 0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = 32'd0;
        end
        @(negedge clk);
        step();
        step();
        mem_clr = 1'b0;
        rstn = 1'b1;

        // preload RAM[5] through m0, then m0 reads it back
        set_m0(1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
        step();
        set_m0(1'b1, 1'b0, 32'd5, 32'd0);
        step();
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("t1_rvalid", 0, 32'(rv0[0]), 32'd1);
        chk("t1_rdata",  0, rd0[0], 32'hDEADBEEF);
        chk("t1_m1_rvalid", 0, 32'(rv1[0]), 32'd0);
        step();

        // both requesters read continuously
        set_m0(1'b1, 1'b0, 32'd10, 32'd0);
        set_m1(1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (gl1[1]) cnt++;
        end
        chk("fixed_prio_m1_grants", 1, 32'(cnt), 32'd0);
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // m1 write, then m0 read of the same word
        set_m1(1'b1, 1'b1, 1'b0, 32'd7, 32'h12345678);
        step();
        set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_m0(1'b1, 1'b0, 32'd7, 32'd0);
        step();
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("t3_rdata", 0, rd0[0], 32'h12345678);
        step();

        // six-cycle locked burst from m1, m0 waiting from cycle 2
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            set_m1(1'b1, 1'b0, 1'b1, 32'd20 + 32'(c), 32'd0);
            set_m0(c >= 2, 1'b0, 32'd10, 32'd0);
            step();
            if (gl0[0] || gl0[2]) cnt++;
        end
        chk("lock_burst_m0_grants", 0, 32'(cnt), 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("lock_release_m0_gnt", 0, 32'(gl0[0]), 32'd1);
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // starvation break with m1 locked continuously
        first_m0 = -1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            set_m1(1'b1, 1'b0, 1'b1, 32'd30, 32'd0);
            set_m0(c >= 1, 1'b0, 32'd40, 32'd0);
            step();
            if (gl0[2] && first_m0 < 0) first_m0 = c;
            if (c == 6) chk("relock_m1_gnt", 2, 32'(gl1[2]), 32'd1);
            if (gl0[0]) cnt++;
        end
        chk("starve_break_cycle", 2, 32'(first_m0), 32'd5);
        chk("lm16_no_break", 0, 32'(cnt), 32'd0);
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // reset taken at the end of a read grant cycle
        set_m0(1'b1, 1'b0, 32'd5, 32'd0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        set_m0(1'b1, 1'b0, 32'd10, 32'd0);
        set_m1(1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
        #1;
        chk("rst_no_rvalid", 0, 32'(rv0[0]), 32'd0);
        chk("rst_prio_m0",   0, 32'(g0[0]),  32'd1);
        step();
        set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        for (int c = 0; c < 600; c++) begin
            rnd_drive();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, read-first block RAM (1-cycle read latency) between two requesters.
- Requester 0 is the core load/store unit; requester 1 is the UART program loader / I/O DMA.
- Grants one access per cycle, using round-robin or fixed priority.
- Supports a lock so requester 1 can burst, with a starvation breaker that protects requester 0.
- Routes the read response back to the requester that issued it.

Parameters:
- RR_ENABLE, 1: 1 = round-robin between m0 and m1; 0 = fixed priority, m0 always wins.
- LOCK_MAX, 16: maximum consecutive cycles m0 may be stalled by an m1 lock before the lock is broken. Range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write enable (1 = write, 0 = read).
- m0_addr  in  32  m0 word address.
- m0_wdata  in  32  m0 write data.
- m0_gnt  out  1  m0 access accepted this cycle (combinational).
- m0_rvalid  out  1  m0 read data valid (registered).
- m0_rdata  out  32  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for requester 1.
- m1_lock  in  1  m1 asks to keep ownership on the following cycle.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_di  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid one cycle after ram_en.

Behaviour:
Grant (combinational, same cycle):
- Only one requester: it is granted.
- Both requesting, RR_ENABLE=1: the requester named by the priority pointer `prio` wins.
- Both requesting, RR_ENABLE=0: m0 wins.
- Lock override: if `locked`=1, m1_req=1 and `starve` < LOCK_MAX, then m1 wins regardless of prio.

RAM drive:
- ram_en = m0_gnt | m1_gnt.
- ram_we, ram_addr and ram_di are muxed from the granted requester.
- No grant: ram_en=0, ram_we=0, ram_addr=0, ram_di=0.
- m0_gnt and m1_gnt are never both 1.

Requester contract:
- A requester holds req, we, addr and wdata stable until it sees gnt.
- A write completes in the grant cycle.
- A read returns data on the next cycle.

Response path:
- Register `rsel` ∈ {none, m0, m1} is set at the edge ending a read grant cycle; it is none for write or idle cycles.
- In the next cycle, mX_rvalid=1 when rsel=mX.
- m0_rdata = m1_rdata = ram_dout; only meaningful when the matching rvalid=1.
- Back-to-back reads from alternating requesters each get exactly one rvalid pulse, in grant order.

Priority pointer (RR_ENABLE=1):
- After any grant, prio points to the requester not granted.
- It is unchanged when there is no grant.

Lock state:
- `locked` is set at an edge where m1_gnt=1 and m1_lock=1.
- It is cleared at any edge where m1_gnt=0, or m1_lock=0, or the starvation break fires.
- m1_lock is ignored when m1 is not being granted.

Starvation counter `starve` (8 bit):
- Increments each cycle m0_req=1 and m0_gnt=0.
- Clears to 0 on m0_gnt, or when m0_req=0.
- Saturates at LOCK_MAX.
- When starve == LOCK_MAX with m0_req=1, m0 is granted that cycle despite the lock; `locked` clears and starve resets.
- If m1 is still requesting with m1_lock, it can re-lock on its next grant.

Reset (rstn=0 at an edge):
- prio=m0, locked=0, starve=0, rsel=none.
- m0_rvalid=0, m1_rvalid=0.
- Combinational gnt and ram_* outputs still follow inputs during reset.
- A read pending when reset is taken produces no rvalid.

Test Plan:
- Read, m0 only: RAM[5]=0xDEADBEEF preloaded; m0 read addr 5. Expect m0_gnt=1 in cycle N, ram_en=1, ram_addr=5; m0_rvalid=1 with m0_rdata=0xDEADBEEF in N+1; m1_rvalid=0 throughout.
- Round-robin: after reset, both request reads continuously (addrs 10 and 20). Expect grants m0, m1, m0, m1…; ram_addr 10, 20, 10, 20; each rvalid one cycle after its own grant. With RR_ENABLE=0, m0 is granted every cycle and m1 never.
- Write then read-first: m1 writes 0x12345678 to addr 7, then m0 reads addr 7 the next cycle. Expect ram_we=1 in cycle 1, m0_rdata=0x12345678 in cycle 3, and no rvalid for the write.
- Lock burst: m1 requests with m1_lock=1 for 6 cycles; m0 requests from cycle 2. Expect m1 granted all 6 cycles (starve stays below 16) and m0 granted the cycle after m1_lock drops.
- Starvation break: LOCK_MAX=4; m1 locked continuously; m0 requests from cycle 1. Expect m0 granted on its 5th requesting cycle, then m1 re-locks on its next grant.
- Reset mid-read: m0 read granted in cycle N, rstn=0 at the edge ending cycle N. Expect m0_rvalid=0 in N+1, prio=m0 and locked=0 after reset.
